// File: rtl/ieee754_pkg.sv
// Shared constants, helpers and beat type for the IEEE-754 datapath blocks.
package ieee754_pkg;
    localparam int SGL_FRAC_W = 23;
    localparam int SGL_EXP_W  = 8;
    localparam int SGL_NORM_W = 28;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    localparam int SGL_SHIFT_W = clog2(SGL_NORM_W);

    typedef struct packed {
        logic [SGL_NORM_W-1:0]  value;
        logic [SGL_SHIFT_W-1:0] shift;
        logic [SGL_EXP_W:0]     tag;
    } norm_beat_t;
endpackage

// File: rtl/ieee754_normalize_pipe_if.sv
// Valid/ready bus of the leading-one normaliser: significand in, normalised fraction out.
interface ieee754_normalize_pipe_if
    import ieee754_pkg::*;
#(
    parameter int WIDTH  = SGL_NORM_W,
    parameter int FRAC_W = SGL_FRAC_W,
    parameter int TAG_W  = SGL_EXP_W + 1
);
    localparam int SHIFT_W = clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_src;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [FRAC_W-1:0]  out_result;
    logic [SHIFT_W-1:0] out_shift;
    logic               out_zero;
    logic               out_sticky;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_src, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_shift, out_zero, out_sticky, out_tag
    );

    modport slave (
        input  in_valid, in_src, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_shift, out_zero, out_sticky, out_tag
    );
endinterface

// File: rtl/ieee754_norm_layer.sv
// One combinational normalise layer: shift left by AMOUNT when the top bits are all zero.
module ieee754_norm_layer
    import ieee754_pkg::*;
#(
    parameter int WIDTH  = SGL_NORM_W,
    parameter int AMOUNT = 16
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] value_o,
    output logic             hit_o
);
    // Never test more bits than the value actually has.
    localparam int TEST_W = (AMOUNT < WIDTH) ? AMOUNT : WIDTH;

    assign hit_o   = (value_i[WIDTH-1 -: TEST_W] == '0);
    assign value_o = hit_o ? (value_i << AMOUNT) : value_i;
endmodule

// File: rtl/ieee754_normalize_pipe.sv
// Pipelined leading-one normaliser with an optional register after each shift layer.
module ieee754_normalize_pipe
    import ieee754_pkg::*;
#(
    parameter int          WIDTH    = SGL_NORM_W,
    parameter int          FRAC_W   = SGL_FRAC_W,
    parameter int          TAG_W    = SGL_EXP_W + 1,
    parameter int unsigned REG_MASK = 32'b00100
) (
    input  logic clk,
    input  logic rst_n,
    ieee754_normalize_pipe_if.slave bus
);
    localparam int LAYERS = clog2(WIDTH);

    logic              last_vld;
    logic [WIDTH-1:0]  last_val;
    logic [LAYERS-1:0] last_sh;
    logic [TAG_W-1:0]  last_tag;
    logic              out_load;

    genvar gi;
    generate
        for (gi = 0; gi < LAYERS; gi = gi + 1) begin : g_layer
            logic              vld_i, vld_o, rdy_i, rdy_o, hit;
            logic [WIDTH-1:0]  val_i, val_o, shifted;
            logic [LAYERS-1:0] sh_i, sh_o, sh_lyr;
            logic [TAG_W-1:0]  tag_i, tag_o;

            if (gi == 0) begin : g_src
                assign vld_i = bus.in_valid;
                assign val_i = bus.in_src;
                assign sh_i  = '0;
                assign tag_i = bus.in_tag;
            end else begin : g_chain
                assign vld_i = g_layer[gi-1].vld_o;
                assign val_i = g_layer[gi-1].val_o;
                assign sh_i  = g_layer[gi-1].sh_o;
                assign tag_i = g_layer[gi-1].tag_o;
            end

            // Ready ripples back combinationally so a full pipe still moves every cycle.
            if (gi == LAYERS - 1) begin : g_sink
                assign rdy_i = out_load;
            end else begin : g_back
                assign rdy_i = g_layer[gi+1].rdy_o;
            end

            ieee754_norm_layer #(
                .WIDTH  (WIDTH),
                .AMOUNT (1 << (LAYERS - 1 - gi))
            ) u_layer (
                .value_i (val_i),
                .value_o (shifted),
                .hit_o   (hit)
            );

            always_comb begin
                sh_lyr                  = sh_i;
                sh_lyr[LAYERS - 1 - gi] = hit;
            end

            if (REG_MASK[gi]) begin : g_reg
                logic              valid_q, valid_d;
                logic [WIDTH-1:0]  val_q, val_d;
                logic [LAYERS-1:0] sh_q, sh_d;
                logic [TAG_W-1:0]  tag_q, tag_d;

                assign rdy_o = !valid_q || rdy_i;

                always_comb begin
                    valid_d = valid_q;
                    val_d   = val_q;
                    sh_d    = sh_q;
                    tag_d   = tag_q;
                    if (rdy_o) begin
                        valid_d = vld_i;
                        if (vld_i) begin
                            val_d = shifted;
                            sh_d  = sh_lyr;
                            tag_d = tag_i;
                        end
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_q <= 1'b0;
                        val_q   <= '0;
                        sh_q    <= '0;
                        tag_q   <= '0;
                    end else begin
                        valid_q <= valid_d;
                        val_q   <= val_d;
                        sh_q    <= sh_d;
                        tag_q   <= tag_d;
                    end
                end

                assign vld_o = valid_q;
                assign val_o = val_q;
                assign sh_o  = sh_q;
                assign tag_o = tag_q;
            end else begin : g_pass
                assign rdy_o = rdy_i;
                assign vld_o = vld_i;
                assign val_o = shifted;
                assign sh_o  = sh_lyr;
                assign tag_o = tag_i;
            end
        end
    endgenerate

    assign last_vld     = g_layer[LAYERS-1].vld_o;
    assign last_val     = g_layer[LAYERS-1].val_o;
    assign last_sh      = g_layer[LAYERS-1].sh_o;
    assign last_tag     = g_layer[LAYERS-1].tag_o;
    assign bus.in_ready = g_layer[0].rdy_o;

    logic              out_valid_q, out_valid_d;
    logic [FRAC_W-1:0] result_q, result_d;
    logic [LAYERS-1:0] shift_q, shift_d;
    logic              zero_q, zero_d;
    logic              sticky_q, sticky_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              norm_zero;
    logic              norm_sticky;

    // A normalised value has its MSB set unless the input was zero.
    assign norm_zero = !last_val[WIDTH-1];

    if (FRAC_W < WIDTH - 1) begin : g_sticky
        assign norm_sticky = |last_val[WIDTH-2-FRAC_W:0];
    end else begin : g_no_sticky
        assign norm_sticky = 1'b0;
    end

    assign out_load = !out_valid_q || bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        sticky_d    = sticky_q;
        tag_d       = tag_q;
        if (out_load) begin
            out_valid_d = last_vld;
            result_d    = '0;
            shift_d     = '0;
            zero_d      = 1'b0;
            sticky_d    = 1'b0;
            tag_d       = '0;
            if (last_vld) begin
                zero_d = norm_zero;
                tag_d  = last_tag;
                if (!norm_zero) begin
                    result_d = last_val[WIDTH-2 -: FRAC_W];
                    shift_d  = last_sh;
                    sticky_d = norm_sticky;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            shift_q     <= '0;
            zero_q      <= 1'b0;
            sticky_q    <= 1'b0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
            sticky_q    <= sticky_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_shift  = shift_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_sticky = sticky_q;
    assign bus.out_tag    = tag_q;
endmodule

// File: doc/ieee754_normalize_pipe.md
Name: ieee754_normalize_pipe

Overview:
- Parametrised, pipelined leading-one normaliser for the FPU datapath.
- Takes an unnormalised significand of WIDTH bits and left-shifts it until the MSB is 1.
- Returns the FRAC_W bits below the implicit one, the shift count, a zero flag and a sticky bit.
- Valid/ready handshake on both sides with full backpressure. A sideband tag (sign/exponent/op id) travels with each beat so the exponent adjust can happen downstream.

Parameters:
- WIDTH, 28, input significand width; 2..64.
- FRAC_W, 23, output fraction width (implicit one dropped); must be <= WIDTH-1.
- TAG_W, 9, sideband width carried unchanged.
- LAYERS, $clog2(WIDTH), number of shift layers (derived, not overridable).
- REG_MASK, 'b00100, LAYERS bits. Bit i=1 inserts a pipeline register after layer i (layer 0 = largest shift).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_src  in  WIDTH  unnormalised significand
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  FRAC_W  normalised fraction, implicit one removed
- out_shift  out  $clog2(WIDTH)  left-shift amount = leading-zero count
- out_zero  out  1  in_src was all zero
- out_sticky  out  1  OR of normalised bits below the result field
- out_tag  out  TAG_W  sideband of this beat

Behaviour:
- Layer k shifts left by 2^(LAYERS-1-k) when the top 2^(LAYERS-1-k) bits of its input are zero, and sets the matching out_shift bit. When that amount would exceed the remaining width, only the valid top bits are tested.
  - out_shift must equal the exact leading-zero count, 0..WIDTH-1.
- After the final layer, bit WIDTH-1 is 1 (unless zero):
  - out_result = norm[WIDTH-2 -: FRAC_W].
  - out_sticky = |norm[WIDTH-2-FRAC_W:0]. It is 0 when FRAC_W = WIDTH-1.
- Zero input: out_zero=1, out_result=0, out_shift=0, out_sticky=0. The all-shift code is not exposed.
- Pipeline structure:
  - Registered stages: one per REG_MASK bit set, plus one mandatory output register.
  - Latency = 1 + popcount(REG_MASK) cycles from accepted input to out_valid.
  - Each stage holds valid, partial shifted value, partial shift bits and tag.
- Handshake:
  - Input is accepted when in_valid & in_ready. Output is consumed when out_valid & out_ready.
  - A stage loads when it is empty or its contents advance this cycle. in_ready = first stage empty or advancing. Ready is computed combinationally back through the stages, so there are no bubbles at full throughput: 1 beat/cycle with out_ready held high.
  - Capacity = number of registered stages. No beat is dropped or duplicated.
  - While out_valid & !out_ready, all out_* remain stable.
  - in_valid must not depend on in_ready. in_src and in_tag are ignored when in_valid=0.
- Simultaneous accept and consume on a full pipeline: both happen, occupancy unchanged.
- Reset (async assert, sync deassert handled at top level):
  - All stage valid bits clear. out_valid=0, out_result=0, out_shift=0, out_zero=0, out_sticky=0, out_tag=0.
  - in_ready=1 on the first cycle after deassertion.
  - Beats in flight when reset asserts mid-operation are discarded.
- Data registers may be reset or not, but outputs must read 0 while out_valid=0 after reset.

Decomposition:
- ieee754_pkg:
  - constants SGL_FRAC_W=23, SGL_EXP_W=8, SGL_NORM_W=28.
  - function clog2.
  - a typedef for the normaliser beat: value, shift, tag.
- Sub-module ieee754_norm_layer:
  - one combinational layer (parameters WIDTH, AMOUNT).
  - outputs the shifted value and one shift bit.
  - instantiated LAYERS times via generate, with an optional register slice after each layer per REG_MASK.

Test Plan (WIDTH=28, FRAC_W=23, REG_MASK='b00100, latency 2):
- in_src=28'h8000000, out_ready=1 → 2 cycles later: result=0, shift=0, zero=0, sticky=0, tag echoed.
- in_src=28'h000001F → shift=23, result=23'h780000, sticky=0. Then in_src=28'h800000F → shift=0, result=0, sticky=1.
- in_src=28'h0000001 → shift=27, result=0, sticky=0. Then in_src=0 → zero=1, result=0, shift=0.
- Back-to-back stream of 100 random inputs with out_ready=1 → one output per cycle, in order; each checked against a reference LZC model with tags matching.
- out_ready=0, in_valid=1 continuously:
  - in_ready drops after exactly 2 beats accepted.
  - Outputs stay stable for 10 cycles.
  - Releasing out_ready drains both beats in order with no loss.
- Assert rst_n=0 with 2 beats in flight:
  - out_valid=0 immediately (asynchronous).
  - After release, in_ready=1 and no stale beats are emitted.
